sequential_logical_compare: RTL
===============================

// Module: sequential_logical_compare
// PURPOSE
//   Multi-cycle, parametrised successor to the single-cycle equality/inequality reducers.
//   Compares two N-bit operands W bits per clock with a valid/ready handshake.
//   Supports an EQ/NEQ mode, optional early exit on first mismatch, and reports the first mismatching chunk.
//   Used where wide operands make a single-cycle N-bit reduction too slow for timing.
// PARAMETERS
//   N          32  operand width in bits; N % W == 0 required (elaboration $error otherwise)
//   W          8   chunk width compared per cycle; K = N/W chunks
//   EARLY_EXIT 1   1: finish on first mismatching chunk; 0: always scan all K chunks
// PORTS
//   clk           in   1              single clock, rising edge
//   rst_n         in   1              asynchronous, active-low reset
//   in_valid      in   1              request valid
//   in_ready      out  1              block can accept a request
//   a             in   N              operand A
//   b             in   N              operand B
//   mode          in   cmp_mode_e     CMP_EQ (0) or CMP_NEQ (1)
//   out_valid     out  1              result valid
//   out_ready     in   1              consumer accepts result
//   c             out  1              result: EQ -> (a==b), NEQ -> (a!=b)
//   mismatch_idx  out  $clog2(K+1)    first mismatching chunk index; K when none found
//   busy          out  1              high in COMPARE or DONE
// BEHAVIOUR
//   Reset (async assert, sync deassert handled upstream): state=IDLE, in_ready=1, out_valid=0,
//     c=0, mismatch_idx=0, busy=0, internal operand/idx/diff registers cleared.
//     Reset mid-operation discards the transaction; no result is produced.
//   FSM: IDLE -> COMPARE on (in_valid && in_ready); a, b, mode latched; idx=0, diff=0.
//     COMPARE: each edge evaluates chunk idx = a_q[idx*W +: W] vs b_q[idx*W +: W].
//       On mismatch with diff==0: diff<=1, first_idx<=idx.
//       Go to DONE if idx==K-1, or if mismatch && EARLY_EXIT; else idx<=idx+1.
//     DONE: out_valid=1; c and mismatch_idx held stable until (out_valid && out_ready),
//       then -> IDLE. c = (mode==CMP_NEQ) ? diff : ~diff; mismatch_idx = diff ? first_idx : K.
//   in_ready=1 only in IDLE; in_valid outside IDLE ignored; a/b/mode changes after accept ignored.
//   Latency: acceptance edge E0; out_valid high after edge E_K (full scan), or E_(j+1) for early
//     exit at chunk j. K=1 gives a result one cycle after accept. No back-to-back: at least one
//     IDLE cycle between result handshake and next acceptance (throughput 1 per K+2 cycles max).
//   out_ready held low: DONE persists indefinitely, outputs stable.
//   idx counter width $clog2(K) (min 1); never exceeds K-1, so no wrap-around.
// STRUCTURE
//   Package sequential_compare_pkg: typedef enum logic {CMP_EQ, CMP_NEQ} cmp_mode_e;
//     typedef enum logic [1:0] {ST_IDLE, ST_COMPARE, ST_DONE} cmp_state_e.
//   Sub-module chunk_neq #(W): combinational W-bit a!=b (reduction-OR of XOR), instantiated once,
//     fed by a W-bit mux of the latched operands indexed by idx.
//   Top: FSM, operand registers, idx counter, diff/first_idx registers, output decode.
// TESTING (N=32, W=8, K=4)
//   a=b=32'hDEADBEEF, mode=EQ -> out_valid 4 cycles after accept, c=1, mismatch_idx=4.
//   a=32'h12345678, b=32'h12345679, NEQ, EARLY_EXIT=1 -> out_valid 1 cycle after accept, c=1, idx=0.
//   a=32'hFF000000, b=32'h00000000, EQ, EARLY_EXIT=1 -> 4 cycles, c=0, idx=3; EARLY_EXIT=0 same timing.
//   a=32'h00FF00FF vs b=0, EARLY_EXIT=0 -> 4 cycles, idx=0 (first mismatch kept), c=(mode==NEQ).
//   Hold out_ready=0 10 cycles in DONE, toggle a/b/in_valid -> c/idx stable, in_ready=0; then release.
//   Assert rst_n=0 during COMPARE chunk 2 -> all outputs at reset values immediately; next request correct.

Source files
------------

// File: rtl/sequential_compare_pkg.sv
//==============================================================================
// Module   : sequential_compare_pkg
// Brief    : Shared types and helpers for the multi-cycle chunked comparator.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package sequential_compare_pkg;

    typedef enum logic {
        CMP_EQ  = 1'b0,
        CMP_NEQ = 1'b1
    } cmp_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_DONE    = 2'd2
    } cmp_state_e;

    // Chunk counter width; a single-chunk operand still needs one bit.
    function automatic int idx_width(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage : sequential_compare_pkg

`default_nettype wire

// File: rtl/sequential_logical_compare_chunk_neq.sv
//==============================================================================
// Module   : chunk_neq
// Brief    : Combinational W-bit inequality (reduction-OR of bitwise XOR).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module chunk_neq #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         neq
);

    assign neq = |(a ^ b);

endmodule : chunk_neq

`default_nettype wire

// File: rtl/sequential_logical_compare.sv
//==============================================================================
// Module   : sequential_logical_compare
// Brief    : Multi-cycle EQ/NEQ comparator, W bits per clock, valid/ready I/O.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module sequential_logical_compare
    import sequential_compare_pkg::*;
#(
    parameter int N          = 32,
    parameter int W          = 8,
    parameter int EARLY_EXIT = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N-1:0]              a,
    input  logic [N-1:0]              b,
    input  cmp_mode_e                 mode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      c,
    output logic [$clog2(N/W+1)-1:0]  mismatch_idx,
    output logic                      busy
);

    localparam int c_num_chunks = N / W;
    localparam int c_idx_w      = idx_width(c_num_chunks);
    localparam int c_midx_w     = $clog2(c_num_chunks + 1);

    localparam logic [c_idx_w-1:0]  c_last_idx = c_idx_w'(c_num_chunks - 1);
    localparam logic [c_midx_w-1:0] c_no_match = c_midx_w'(c_num_chunks);

    if ((W < 1) || (N % W != 0)) begin : g_width_check
        $error("sequential_logical_compare: N (%0d) must be a multiple of W (%0d)", N, W);
    end

    cmp_state_e           r_state;
    cmp_state_e           w_state_nxt;
    logic [N-1:0]         r_a;
    logic [N-1:0]         r_b;
    cmp_mode_e            r_mode;
    logic [c_idx_w-1:0]   r_idx;
    logic                 r_diff;
    logic [c_idx_w-1:0]   r_first_idx;

    logic [W-1:0]         w_a_chunk;
    logic [W-1:0]         w_b_chunk;
    logic                 w_neq;
    logic                 w_accept;
    logic                 w_scan_done;

    //--------------------------------------------------------------------------
    // Chunk select and single shared comparator
    //--------------------------------------------------------------------------
    always_comb begin
        w_a_chunk = '0;
        w_b_chunk = '0;
        for (int k = 0; k < c_num_chunks; k++) begin
            if (r_idx == c_idx_w'(k)) begin
                w_a_chunk = r_a[k*W +: W];
                w_b_chunk = r_b[k*W +: W];
            end
        end
    end

    chunk_neq #(
        .W   (W)
    ) u_chunk_neq (
        .a   (w_a_chunk),
        .b   (w_b_chunk),
        .neq (w_neq)
    );

    assign w_accept    = in_valid && (r_state == ST_IDLE);
    assign w_scan_done = (r_idx == c_last_idx) || (w_neq && (EARLY_EXIT != 0));

    //--------------------------------------------------------------------------
    // FSM: state register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // FSM: next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (in_valid)    w_state_nxt = ST_COMPARE;
            ST_COMPARE: if (w_scan_done) w_state_nxt = ST_DONE;
            ST_DONE:    if (out_ready)   w_state_nxt = ST_IDLE;
            default:                     w_state_nxt = ST_IDLE;
        endcase
    end

    //--------------------------------------------------------------------------
    // FSM: output decode; result outputs read zero outside DONE
    //--------------------------------------------------------------------------
    always_comb begin
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        c            = 1'b0;
        mismatch_idx = '0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
            end
            ST_COMPARE: begin
                busy = 1'b1;
            end
            ST_DONE: begin
                busy         = 1'b1;
                out_valid    = 1'b1;
                c            = (r_mode == CMP_NEQ) ? r_diff : ~r_diff;
                mismatch_idx = r_diff ? c_midx_w'(r_first_idx) : c_no_match;
            end
            default: ;
        endcase
    end

    //--------------------------------------------------------------------------
    // Datapath: operand capture, chunk walk, first-mismatch tracking
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_mode      <= CMP_EQ;
            r_idx       <= '0;
            r_diff      <= 1'b0;
            r_first_idx <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a         <= a;
                        r_b         <= b;
                        r_mode      <= mode;
                        r_idx       <= '0;
                        r_diff      <= 1'b0;
                        r_first_idx <= '0;
                    end
                end
                ST_COMPARE: begin
                    // Only the earliest mismatching chunk is recorded.
                    if (w_neq && !r_diff) begin
                        r_diff      <= 1'b1;
                        r_first_idx <= r_idx;
                    end
                    if (!w_scan_done) begin
                        r_idx <= r_idx + c_idx_w'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : sequential_logical_compare

`default_nettype wire
